dm_store_buffer: RTL and testbench
==================================

// Module: dm_store_buffer
// PURPOSE
//  Posted-store FIFO between the datapath store path and the data memory write port.
//  Accepts sw/sh/sb requests in one cycle, then drains them one per cycle into the DM write inputs.
//  Loads that hit a buffered word raise ld_stall until that word has drained (no forwarding).
//  Reads bypass the buffer: the DM read port is driven directly by the datapath.
// PARAMETERS
//  DEPTH   4   entries; power of two, >=2
//  PTR_W   2   log2(DEPTH); pointer width
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high; clears all state
//  st_valid     in   1   store request present this cycle
//  st_ready     out  1   buffer can accept a store (= !full)
//  st_addr      in   32  store byte address
//  st_data      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  st_sel       in   2   00 word, 01 half, 10 byte, 11 treated as word
//  st_pcadd4    in   32  PC+4 of the store instruction (trace/display)
//  ld_req       in   1   load in progress this cycle
//  ld_addr      in   32  load byte address
//  ld_stall     out  1   load conflicts with a buffered store; datapath must hold
//  drain_hold   in   1   inhibit draining this cycle
//  dm_en        out  1   DM write enable
//  dm_addr      out  32  DM address of head entry
//  dm_di        out  32  DM write data of head entry
//  dm_sel       out  2   DM access size of head entry
//  dm_pcadd4    out  32  PC+4 of head entry
//  count        out  PTR_W+1  occupied entries
//  empty        out  1   count == 0
// BEHAVIOUR
//  - Storage: DEPTH entries of {addr, data, sel, pcadd4}; head ptr (rd), tail ptr (wr), count reg.
//  - Reset (async, any time, including mid-drain): rd=wr=0, count=0; all entries' valid
//    cleared; in-flight drain discarded. Outputs after reset: st_ready=1, empty=1, count=0,
//    dm_en=0, ld_stall=0; dm_addr/dm_di/dm_sel/dm_pcadd4 = 0.
//  - Push: st_valid && st_ready at posedge -> entry[wr] written, wr<=wr+1 (mod DEPTH).
//    st_valid while !st_ready is dropped; the datapath must hold the store (no internal retry).
//  - Drain: dm_en = !empty && !drain_hold, combinational. dm_* show entry[rd] whenever !empty,
//    0 when empty. Posedge with dm_en -> rd<=rd+1 (mod DEPTH); the DM samples dm_* the same edge.
//  - Latency: a store pushed at edge N is on dm_* during cycle N+1 when buffer was empty and
//    drain_hold=0; written to DM at edge N+1. Empty->push->drain never bypasses the registers.
//  - count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
//    st_ready = (count != DEPTH); a pop in the same cycle does not reopen a full buffer early.
//  - Simultaneous push+pop at count==1: new entry lands at wr, head pops; count stays 1.
//  - Pointer wrap: rd/wr are PTR_W bits and wrap silently; full/empty decided by count only.
//  - ld_stall = ld_req && (any valid entry with entry.addr[11:2] == ld_addr[11:2]).
//    Compared on word index only, same granularity as DM; size/byte lane ignored (conservative).
//    Head entry being drained this cycle still counts as a hit; stall drops the cycle after pop.
//    An st_valid in the same cycle is not compared (the store is not yet in the buffer).
//  - No data merging or reordering: DM write order equals push order.
// TESTING
//  T1 reset: assert reset mid-cycle with 3 entries queued -> count=0, empty=1, dm_en=0 at once,
//     no further DM writes.
//  T2 single sw: push addr=0x0000_0010 data=0xDEAD_BEEF sel=00 -> next cycle dm_en=1,
//     dm_addr=0x10, dm_di=0xDEADBEEF; following cycle empty=1.
//  T3 fill: drain_hold=1, push 4 stores -> count=4, st_ready=0; 5th st_valid ignored;
//     release hold -> 4 dm_en pulses in push order, count 4,3,2,1,0.
//  T4 wrap: 10 push/pop pairs back-to-back with drain_hold=0 -> count stays <=1, order kept,
//     rd/wr wrap past 3 correctly.
//  T5 ld conflict: drain_hold=1, sb addr=0x0000_0023 buffered; ld_req addr=0x0000_0020
//     -> ld_stall=1; ld_addr=0x0000_0024 -> ld_stall=0; release hold -> stall low after pop.
//  T6 push+pop at full: count=4, drain_hold=0, st_valid=1 -> pop occurs, push dropped,
//     count=3, st_ready=1 next cycle.

Source files
------------

// File: rtl/dm_store_buffer.sv
// dm_store_buffer
//   Posted-store FIFO between the datapath store path and the data memory
//   write port. It accepts one sw/sh/sb per cycle and drains the oldest entry
//   to the DM write inputs once per cycle. A load that hits a buffered word
//   raises ld_stall until that word has drained; data is never forwarded.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   st_valid/st_ready           store handshake; a store offered while full is dropped
//   st_addr/st_data/st_sel      store byte address, right-aligned data, size
//                               (00 word, 01 half, 10 byte, 11 word)
//   st_pcadd4                   PC+4 of the store, carried for trace
//   ld_req/ld_addr/ld_stall     load word-conflict check against buffered stores
//   drain_hold                  inhibits draining this cycle
//   dm_en/dm_addr/dm_di/dm_sel/dm_pcadd4   head entry presented to the DM
//   count/empty                 occupancy
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_sel,
  input  logic [31:0]      st_pcadd4,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  input  logic             drain_hold,
  output logic             dm_en,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_di,
  output logic [1:0]       dm_sel,
  output logic [31:0]      dm_pcadd4,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][31:0] addr_q, data_q, pc_q;
  logic [DEPTH-1:0][1:0]  sel_q;
  logic [DEPTH-1:0]       vld_q;
  logic [PTR_W-1:0]       rd, wr;
  logic [PTR_W:0]         cnt;
  logic                   push, pop, hit;

  // Only the word index participates in the conflict check.
  logic unused_ld_bits;
  assign unused_ld_bits = ^{ld_addr[31:12], ld_addr[1:0]};

  assign count    = cnt;
  assign empty    = (cnt == '0);
  // A pop in the same cycle does not reopen a full buffer: readiness is
  // decided from the registered count alone.
  assign st_ready = (cnt != FULL);
  assign push     = st_valid && st_ready;
  assign dm_en    = !empty && !drain_hold;
  assign pop      = dm_en;

  assign dm_addr   = empty ? '0 : addr_q[rd];
  assign dm_di     = empty ? '0 : data_q[rd];
  assign dm_sel    = empty ? '0 : sel_q[rd];
  assign dm_pcadd4 = empty ? '0 : pc_q[rd];

  // The head entry keeps its valid bit until the edge that pops it, so a
  // load against the draining word still stalls this cycle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && (addr_q[i][11:2] == ld_addr[11:2])) hit = 1'b1;
  end
  assign ld_stall = ld_req && hit;

  // push and pop never target the same slot: that would need count==0
  // (no pop) or count==DEPTH (no push).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      pc_q   <= '0;
      sel_q  <= '0;
      vld_q  <= '0;
      rd     <= '0;
      wr     <= '0;
      cnt    <= '0;
    end else begin
      if (pop) begin
        vld_q[rd] <= 1'b0;
        rd        <= rd + 1'b1;
      end
      if (push) begin
        addr_q[wr] <= st_addr;
        data_q[wr] <= st_data;
        sel_q[wr]  <= st_sel;
        pc_q[wr]   <= st_pcadd4;
        vld_q[wr]  <= 1'b1;
        wr         <= wr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 0, reset = 1;
  logic st_valid = 0, ld_req = 0, drain_hold = 0;
  logic [31:0] st_addr = 0, st_data = 0, st_pcadd4 = 0, ld_addr = 0;
  logic [1:0]  st_sel = 0;
  logic st_ready, ld_stall, dm_en, empty;
  logic [31:0] dm_addr, dm_di, dm_pcadd4;
  logic [1:0]  dm_sel;
  logic [PTR_W:0] count;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel), .st_pcadd4(st_pcadd4),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall), .drain_hold(drain_hold),
    .dm_en(dm_en), .dm_addr(dm_addr), .dm_di(dm_di), .dm_sel(dm_sel),
    .dm_pcadd4(dm_pcadd4), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   mcount = 0;
  int   n_wr = 0;
  int   n_chk = 0, n_err = 0;
  logic pop_e, push_e, stall_e;
  ent_t e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted stores are queued, the head is compared every cycle
  // it is on dm_*, and popped when the DM takes it.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      mcount = 0;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_ready", 32'(st_ready), 1);
      chk("rst_dm_en", 32'(dm_en), 0);
      chk("rst_stall", 32'(ld_stall), 0);
      chk("rst_dm_addr", dm_addr, 0);
      chk("rst_dm_di", dm_di, 0);
    end else begin
      pop_e  = (mcount > 0) && !drain_hold;
      push_e = st_valid && (mcount < DEPTH);
      stall_e = 1'b0;
      foreach (q[i]) if (ld_req && q[i].a[11:2] == ld_addr[11:2]) stall_e = 1'b1;
      chk("count", 32'(count), 32'(mcount));
      chk("empty", 32'(empty), 32'(mcount == 0));
      chk("st_ready", 32'(st_ready), 32'(mcount != DEPTH));
      chk("dm_en", 32'(dm_en), 32'(pop_e));
      chk("ld_stall", 32'(ld_stall), 32'(stall_e));
      if (mcount > 0) begin
        chk("dm_addr", dm_addr, q[0].a);
        chk("dm_di", dm_di, q[0].d);
        chk("dm_sel", 32'(dm_sel), 32'(q[0].s));
        chk("dm_pcadd4", dm_pcadd4, q[0].pc);
      end else begin
        chk("dm_addr_idle", dm_addr, 0);
        chk("dm_di_idle", dm_di, 0);
      end
      if (pop_e) begin
        void'(q.pop_front());
        n_wr++;
      end
      if (push_e) begin
        e.a = st_addr; e.d = st_data; e.s = st_sel; e.pc = st_pcadd4;
        q.push_back(e);
      end
      mcount = mcount + (push_e ? 1 : 0) - (pop_e ? 1 : 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1; st_addr = a; st_data = d; st_sel = s; st_pcadd4 = a + 32'h1000;
    tick();
  endtask

  int w0;

  initial begin
    tick(2);
    reset = 0;

    // single sw
    w0 = n_wr;
    offer(32'h10, 32'hDEAD_BEEF, 2'b00);
    st_valid = 0;
    chk("t2_dm_en", 32'(dm_en), 1);
    chk("t2_dm_addr", dm_addr, 32'h10);
    chk("t2_dm_di", dm_di, 32'hDEAD_BEEF);
    tick();
    chk("t2_empty", 32'(empty), 1);
    chk("t2_writes", 32'(n_wr - w0), 1);

    // fill under hold, fifth offer dropped, then drain in order
    drain_hold = 1;
    for (int i = 0; i < 5; i++) offer(32'h100 + 32'(i) * 4, 32'hA000_0000 + 32'(i), 2'(i));
    st_valid = 0;
    chk("t3_count", 32'(count), 4);
    chk("t3_ready", 32'(st_ready), 0);
    w0 = n_wr;
    drain_hold = 0;
    tick(5);
    chk("t3_writes", 32'(n_wr - w0), 4);

    // back-to-back push/pop, pointers wrap
    w0 = n_wr;
    for (int i = 0; i < 10; i++) offer(32'h200 + 32'(i) * 4, 32'hB000_0000 + 32'(i), 2'b00);
    st_valid = 0;
    tick(2);
    chk("t4_writes", 32'(n_wr - w0), 10);

    // load conflict on word index
    drain_hold = 1;
    offer(32'h23, 32'h0000_00AB, 2'b10);
    st_valid = 0;
    ld_req = 1; ld_addr = 32'h20;
    #1 chk("t5_hit", 32'(ld_stall), 1);
    tick();
    ld_addr = 32'h24;
    #1 chk("t5_miss", 32'(ld_stall), 0);
    tick();
    ld_addr = 32'h20; drain_hold = 0;
    #1 chk("t5_hit_draining", 32'(ld_stall), 1);
    tick();
    chk("t5_after_pop", 32'(ld_stall), 0);
    ld_req = 0;

    // offer while full with drain open: pop happens, push dropped
    drain_hold = 1;
    for (int i = 0; i < 4; i++) offer(32'h300 + 32'(i) * 4, 32'hC000_0000 + 32'(i), 2'b01);
    drain_hold = 0;
    offer(32'h3F0, 32'hDEAD_0000, 2'b00);
    st_valid = 0;
    chk("t6_count", 32'(count), 3);
    chk("t6_ready", 32'(st_ready), 1);
    tick(4);

    // reset mid-cycle with 3 queued
    drain_hold = 1;
    for (int i = 0; i < 3; i++) offer(32'h400 + 32'(i) * 4, 32'hD000_0000 + 32'(i), 2'b00);
    st_valid = 0;
    #2 reset = 1;
    #1 chk("t1_count", 32'(count), 0);
    chk("t1_empty", 32'(empty), 1);
    chk("t1_dm_en", 32'(dm_en), 0);
    drain_hold = 0;
    w0 = n_wr;
    tick(2);
    reset = 0;
    tick(3);
    chk("t1_no_writes", 32'(n_wr - w0), 0);

    // random traffic with a small address set so loads hit often
    for (int i = 0; i < 60; i++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      st_data = $urandom; st_sel = 2'($urandom_range(0, 3)); st_pcadd4 = $urandom;
      drain_hold = ($urandom_range(0, 2) == 0);
      ld_req = 1'($urandom_range(0, 1));
      ld_addr = 32'($urandom_range(0, 7)) * 4;
      tick();
    end
    st_valid = 0; drain_hold = 0; ld_req = 0;
    tick(6);
    chk("final_empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
